// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/checker pair: FSM state encoding,
// parity-sense constants and the parity reference helper.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  // Value the parity bit must take given the XOR of the data bits.
  function automatic logic expected_parity(input logic running, input int odd);
    return running ^ (odd != 0);
  endfunction

endpackage

// File: rtl/parity_frame_checker.sv
// Serial frame receiver + parity/framing checker; outputs registered 1 clk after the stop sample,
// no backpressure (x_valid gates sampling). `PARITY_ERR_COUNT_EN adds a saturating err_count.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x,
  input  logic              x_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_done,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                run_par;
  logic                par_flag;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      run_par    <= 1'b0;
      par_flag   <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (x_valid) begin
        case (state)
          IDLE: begin
            if (!x) begin
              state   <= DATA;
              bit_cnt <= '0;
              run_par <= 1'b0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            // LSB arrives first, so shifting in from the top leaves it in bit 0.
            shreg   <= {x, shreg[DATA_W-1:1]};
            run_par <= run_par ^ x;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          PARITY: begin
            par_flag <= (x != expected_parity(run_par, ODD));
            state    <= STOP;
          end
          STOP: begin
            data_out   <= shreg;
            parity_err <= par_flag;
            frame_err  <= ~x;
            frame_done <= 1'b1;
            state      <= x ? IDLE : BREAK;
            busy       <= ~x;
          end
          BREAK: begin
            if (x) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  // Counted on the stop-sample edge so the count is current while frame_done is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (x_valid && (state == STOP) && (!x || par_flag) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized frame stimulus on an even- and an odd-parity checker, scored against a frame-level model.
module tb_parity_frame_checker;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic x = 1'b1;
  logic x_valid = 1'b0;

  logic [DW-1:0] do0, do1;
  logic fd0, fd1, pe0, pe1, fe0, fe1, bz0, bz1;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0] ec0, ec1;
`endif

  parity_frame_checker #(.DATA_W(DW), .ODD(0)) dut0 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
    .data_out(do0), .frame_done(fd0), .parity_err(pe0), .frame_err(fe0), .busy(bz0)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(ec0)
`endif
  );

  parity_frame_checker #(.DATA_W(DW), .ODD(1)) dut1 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid),
    .data_out(do1), .frame_done(fd1), .parity_err(pe1), .frame_err(fe1), .busy(bz1)
`ifdef PARITY_ERR_COUNT_EN
    , .err_count(ec1)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int ecount = 0;
  bit chk_en = 1'b0;
  int gap_mode = 0;

  // Model: frames whose stop bit was sampled, each due on a known edge count.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
    bit            pbit;
    bit            stop;
  } rec_t;
  rec_t q[$];

  logic [DW-1:0] exp_data[2];
  int            exp_cnt[2];
  bit            exp_busy;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process.
  rec_t cur;
  bit   exp_fd;
  bit   exp_pe[2];
  bit   exp_fe;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_fd = 1'b0;
      exp_pe[0] = 1'b0;
      exp_pe[1] = 1'b0;
      exp_fe = 1'b0;
      if (q.size() > 0 && q[0].due == ecount) begin
        cur = q.pop_front();
        exp_fd = 1'b1;
        exp_fe = !cur.stop;
        for (int k = 0; k < 2; k++) begin
          exp_pe[k] = (cur.pbit != ((^cur.data) ^ k[0]));
          exp_data[k] = cur.data;
          if ((exp_pe[k] || exp_fe) && exp_cnt[k] < 255) exp_cnt[k]++;
        end
      end
      chk("frame_done0", fd0, exp_fd);
      chk("frame_done1", fd1, exp_fd);
      chk("data_out0", do0, exp_data[0]);
      chk("data_out1", do1, exp_data[1]);
      chk("busy0", bz0, exp_busy);
      chk("busy1", bz1, exp_busy);
      if (exp_fd) begin
        chk("parity_err0", pe0, exp_pe[0]);
        chk("parity_err1", pe1, exp_pe[1]);
        chk("frame_err0", fe0, exp_fe);
        chk("frame_err1", fe1, exp_fe);
      end
`ifdef PARITY_ERR_COUNT_EN
      chk("err_count0", ec0, exp_cnt[0]);
      chk("err_count1", ec1, exp_cnt[1]);
`endif
    end
  end

  // One valid sample, preceded by invalid cycles carrying garbage on x.
  task automatic samp(input bit v);
    int ngap;
    ngap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
    repeat (ngap) begin
      x_valid = 1'b0;
      x = 1'($urandom);
      @(posedge clk); #1;
    end
    x_valid = 1'b1;
    x = v;
    @(posedge clk); #1;
    x_valid = 1'b0;
    x = 1'b1;
  endtask

  task automatic send_body(input logic [DW-1:0] d, input bit pbit, input bit stop);
    rec_t r;
    samp(1'b0);
    exp_busy = 1'b1;
    for (int i = 0; i < DW; i++) samp(d[i]);
    samp(pbit);
    samp(stop);
    r.due = ecount;
    r.data = d;
    r.pbit = pbit;
    r.stop = stop;
    q.push_back(r);
    if (stop) exp_busy = 1'b0;
  endtask

  task automatic break_end(input int n);
    repeat (n) begin
      samp(1'b0);
      chk("break_busy", bz0, 1);
    end
    samp(1'b1);
    exp_busy = 1'b0;
  endtask

  task automatic do_reset();
    x_valid = 1'b1;
    x = 1'($urandom);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    x_valid = 1'b0;
    x = 1'b1;
    q.delete();
    exp_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0;
      exp_cnt[k] = 0;
    end
  endtask

  logic [DW-1:0] rd;
  bit rpb, rst_bit;

  initial begin
    exp_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_data[k] = '0;
      exp_cnt[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk_en = 1'b1;

    chk("rst_data_out", do0, 0);
    chk("rst_frame_done", fd0, 0);
    chk("rst_parity_err", pe0, 0);
    chk("rst_frame_err", fe0, 0);
    chk("rst_busy", bz0, 0);
`ifdef PARITY_ERR_COUNT_EN
    chk("rst_err_count", ec0, 0);
`endif
    samp(1'b1);

    // Good frame 0xA5, even parity bit 0.
    send_body(8'hA5, 1'b0, 1'b1);
    chk("a5_data", do0, 8'hA5);
    chk("a5_done", fd0, 1);
    chk("a5_perr", pe0, 0);
    chk("a5_ferr", fe0, 0);
    chk("a5_busy", bz0, 0);
    samp(1'b1);
    chk("a5_done_drop", fd0, 0);

    // Parity error 0x07 with bit 0.
    send_body(8'h07, 1'b0, 1'b1);
    chk("p07_data", do0, 8'h07);
    chk("p07_perr_even", pe0, 1);
    chk("p07_perr_odd", pe1, 0);
`ifdef PARITY_ERR_COUNT_EN
    chk("p07_cnt", ec0, 1);
`endif
    samp(1'b1);

    // Framing error 0x3C, stop 0, 5 low samples, then high.
    send_body(8'h3C, 1'b0, 1'b0);
    chk("f3c_ferr", fe0, 1);
    chk("f3c_done", fd0, 1);
    chk("f3c_busy", bz0, 1);
    break_end(5);
    chk("f3c_idle", bz0, 0);
    samp(1'b1);

    // Gapped strobe 0x5A.
    gap_mode = 1;
    send_body(8'h5A, 1'b0, 1'b1);
    chk("g5a_data", do0, 8'h5A);
    chk("g5a_perr", pe0, 0);
    chk("g5a_ferr", fe0, 0);
    samp(1'b1);
    gap_mode = 0;

    // Reset in the middle of 0xFF, then 0x81 with parity bit 1.
    samp(1'b0);
    exp_busy = 1'b1;
    repeat (4) samp(1'b1);
    do_reset();
    chk("abort_data", do0, 0);
    chk("abort_busy", bz0, 0);
    samp(1'b1);
    send_body(8'h81, 1'b1, 1'b1);
    chk("r81_data_odd", do1, 8'h81);
    chk("r81_perr_odd", pe1, 0);
    chk("r81_perr_even", pe0, 1);

    // Back-to-back 0x01 then 0xFE.
    send_body(8'h01, 1'b1, 1'b1);
    chk("b2b_first", do0, 8'h01);
    send_body(8'hFE, 1'b1, 1'b1);
    chk("b2b_second", do0, 8'hFE);
    chk("b2b_perr", pe0, 0);

    // Randomized frames.
    for (int f = 0; f < 120; f++) begin
      gap_mode = $urandom_range(0, 2);
      rd = DW'($urandom);
      rpb = (^rd) ^ ($urandom_range(0, 3) == 0);
      rst_bit = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 19) == 0) begin
        samp(1'b0);
        exp_busy = 1'b1;
        repeat ($urandom_range(0, 9)) samp(1'($urandom));
        do_reset();
      end else begin
        send_body(rd, rpb, rst_bit);
        if (!rst_bit) break_end($urandom_range(0, 4));
      end
      repeat ($urandom_range(0, 2)) samp(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
